// File: rtl/iob_pcie_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iob_pcie_pkg
// Purpose  : Shared definitions for the PCIe receive-channel engine. Holds the
//            32-bit word width, the receive FSM state encoding and helpers that
//            derive the words-per-beat ratio (RATIO) and the width of the
//            per-beat word-count field (NW_W) from the channel data width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package iob_pcie_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_RECV  = 2'd2,
    ST_DRAIN = 2'd3
  } rx_state_t;

  // Words carried by one channel beat.
  function automatic int ratio_of(input int data_w);
    return data_w / WORD_W;
  endfunction

  // Bits needed to hold a word count in the range 1..RATIO.
  function automatic int nw_width(input int data_w);
    return $clog2(data_w / WORD_W) + 1;
  endfunction

  // Values for the default 64-bit channel.
  localparam int RATIO = ratio_of(64);
  localparam int NW_W  = nw_width(64);

endpackage : iob_pcie_pkg
`default_nettype wire

// File: rtl/iob_pcie_rx_unpack.sv
`default_nettype none
// ============================================================================
// Module   : iob_pcie_rx_unpack
// Purpose  : Read side of the beat buffer. Pops one {nwords, beat} entry at a
//            time and presents its words, lowest lane first, on a valid/ready
//            word stream. Lanes beyond nwords are never presented.
// Ports    : clk, rst (async active-low)
//            fifo_empty_i / fifo_data_i / fifo_pop_o : buffer read interface
//            rd_data_o / rd_valid_o / rd_ready_i     : 32-bit word stream
//            idle_o                                  : no entry held
// Revision : 1.0 - initial release
// ============================================================================
module iob_pcie_rx_unpack
  import iob_pcie_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NW_W_P = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_empty_i,
  input  logic [DATA_W+NW_W_P-1:0] fifo_data_i,
  output logic                     fifo_pop_o,
  output logic [WORD_W-1:0]        rd_data_o,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic                     idle_o
);

  logic [DATA_W-1:0] beat_q;
  logic [NW_W_P-1:0] left_q;
  logic              valid_q;
  logic              take;
  logic              last_take;
  logic              pop;

  assign take      = valid_q && rd_ready_i;
  assign last_take = take && (left_q == NW_W_P'(1));
  // Refill in the same cycle the final word leaves, so a steady stream keeps
  // one word per cycle with no bubble between beats.
  assign pop       = (!valid_q || last_take) && !fifo_empty_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_q  <= '0;
      left_q  <= '0;
      valid_q <= 1'b0;
    end else if (pop) begin
      beat_q  <= fifo_data_i[DATA_W-1:0];
      left_q  <= fifo_data_i[DATA_W +: NW_W_P];
      valid_q <= 1'b1;
    end else if (last_take) begin
      left_q  <= '0;
      valid_q <= 1'b0;
    end else if (take) begin
      // The current word always sits in the low lane; shifting brings the
      // next one down, so no lane multiplexer is needed.
      beat_q  <= beat_q >> WORD_W;
      left_q  <= left_q - NW_W_P'(1);
    end
  end

  assign fifo_pop_o = pop;
  assign rd_data_o  = beat_q[WORD_W-1:0];
  assign rd_valid_o = valid_q;
  assign idle_o     = !valid_q;

endmodule : iob_pcie_rx_unpack
`default_nettype wire

// File: rtl/iob_pcie_rx_chnl.sv
`default_nettype none
// ============================================================================
// Module   : iob_pcie_rx_chnl
// Purpose  : Receive-channel engine. Detects a new transaction, acknowledges
//            it, counts beats against the advertised length, buffers them and
//            hands them to the unpacker, flags early termination and pulses
//            done once every accepted word has been delivered.
// Ports    : clk, rst (async active-low)
//            chnl_rx_*      : channel request, length/offset/last, beat data,
//                             beat valid, beat consume (ren) and ack
//            rd_*           : 32-bit word stream towards the CPU side
//            busy_o/done_o  : activity and completion pulse
//            err_o / clr_i  : sticky early-termination error and its clear
//            len_o/off_o/last_o/rcvd_o : latched request and words accepted
// Revision : 1.0 - initial release
// ============================================================================
module iob_pcie_rx_chnl
  import iob_pcie_pkg::*;
#(
  parameter int PCI_DATA_W  = 64,
  parameter int FIFO_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chnl_rx_i,
  input  logic                  chnl_rx_last_i,
  input  logic [31:0]           chnl_rx_len_i,
  input  logic [30:0]           chnl_rx_off_i,
  input  logic [PCI_DATA_W-1:0] chnl_rx_data_i,
  input  logic                  chnl_rx_data_valid_i,
  output logic                  chnl_rx_data_ren_o,
  output logic                  chnl_rx_ack_o,
  output logic [31:0]           rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  input  logic                  clr_i,
  output logic [31:0]           len_o,
  output logic [30:0]           off_o,
  output logic                  last_o,
  output logic [31:0]           rcvd_o
);

  localparam int CH_RATIO = ratio_of(PCI_DATA_W);
  localparam int CH_NW_W  = nw_width(PCI_DATA_W);
  localparam int ENTRY_W  = PCI_DATA_W + CH_NW_W;
  localparam int DEPTH    = 2 ** FIFO_ADDR_W;
  localparam logic [FIFO_ADDR_W:0] FULL_CNT = {1'b1, {FIFO_ADDR_W{1'b0}}};

  rx_state_t state, state_nxt;

  logic        armed;
  logic [31:0] len_q;
  logic [30:0] off_q;
  logic        last_q;
  logic [31:0] rcvd_q;
  logic        err_q;
  logic        done_q;

  logic        start;
  logic        set_err;
  logic        finish;

  // Beat buffer
  logic [ENTRY_W-1:0]     mem [DEPTH];
  logic [FIFO_ADDR_W-1:0] wr_ptr;
  logic [FIFO_ADDR_W-1:0] rd_ptr;
  logic [FIFO_ADDR_W:0]   count;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   unpack_idle;

  logic [31:0]        rem;
  logic [CH_NW_W-1:0] nwords;
  logic [31:0]        rcvd_nxt;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // ren depends only on registered state and count: no input-to-output path.
  assign chnl_rx_data_ren_o = (state == ST_RECV) && !full;
  assign push               = chnl_rx_data_ren_o && chnl_rx_data_valid_i;

  // The final beat may carry fewer than RATIO words; clamping here keeps
  // rcvd from ever passing len.
  assign rem      = len_q - rcvd_q;
  assign nwords   = (rem >= 32'(CH_RATIO)) ? CH_NW_W'(CH_RATIO) : rem[CH_NW_W-1:0];
  assign rcvd_nxt = rcvd_q + {{(32-CH_NW_W){1'b0}}, nwords};

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    set_err   = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (chnl_rx_i && armed) begin
          state_nxt = ST_ACK;
          start     = 1'b1;
        end
      end
      ST_ACK: begin
        state_nxt = (len_q == 32'd0) ? ST_DRAIN : ST_RECV;
      end
      ST_RECV: begin
        if (push && (rcvd_nxt == len_q)) begin
          state_nxt = ST_DRAIN;
        end else if (!chnl_rx_i) begin
          // Request withdrawn before the full length arrived.
          state_nxt = ST_DRAIN;
          set_err   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (empty && unpack_idle) begin
          state_nxt = ST_IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      armed  <= 1'b1;
      len_q  <= '0;
      off_q  <= '0;
      last_q <= 1'b0;
      rcvd_q <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= finish;

      // A request that is still high after completion must not restart.
      if (start) begin
        armed <= 1'b0;
      end else if (!chnl_rx_i) begin
        armed <= 1'b1;
      end

      if (start) begin
        len_q  <= chnl_rx_len_i;
        off_q  <= chnl_rx_off_i;
        last_q <= chnl_rx_last_i;
        rcvd_q <= '0;
      end else if (push) begin
        rcvd_q <= rcvd_nxt;
      end

      // A new error takes priority over a coincident clear.
      if (set_err) begin
        err_q <= 1'b1;
      end else if (clr_i) begin
        err_q <= 1'b0;
      end
    end
  end

  // Beat buffer: pointers and count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_ADDR_W+1)'(1);
        2'b01:   count <= count - (FIFO_ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; contents are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {nwords, chnl_rx_data_i};
  end

  iob_pcie_rx_unpack #(
    .DATA_W (PCI_DATA_W),
    .NW_W_P (CH_NW_W)
  ) u_unpack (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty_i (empty),
    .fifo_data_i  (mem[rd_ptr]),
    .fifo_pop_o   (pop),
    .rd_data_o    (rd_data_o),
    .rd_valid_o   (rd_valid_o),
    .rd_ready_i   (rd_ready_i),
    .idle_o       (unpack_idle)
  );

  assign chnl_rx_ack_o = (state == ST_ACK);
  assign busy_o        = (state != ST_IDLE);
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign len_o         = len_q;
  assign off_o         = off_q;
  assign last_o        = last_q;
  assign rcvd_o        = rcvd_q;

endmodule : iob_pcie_rx_chnl
`default_nettype wire
